alu_div_sequencer: RTL and testbench

- Multi-cycle controller for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU). The single-cycle ALU does not implement these.
- Sits beside the ALU in the execute stage. Decode raises start; the core stalls while busy is high and writes back result when done pulses.
- Uses a restoring shift-subtract loop, 1 quotient bit per cycle, with sign pre/post-processing and a fast path for RISC-V special cases.

---
 rtl/alu_div_sequencer_if.sv | 23 ++
 rtl/alu_div_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_div_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_div_sequencer_if.sv
// Request/response bundle between decode/writeback and the RV32M divide sequencer.
// The decode side drives start/op/operands; the sequencer returns busy/done/result.
interface alu_div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU: restoring divide, one quotient bit per cycle.
// Optional last-result cache enabled by defining ALU_DIV_RESULT_CACHE_EN.
module alu_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_div_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] dividend_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [1:0]      op_reg;
    logic [XLEN-1:0] dsr_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] quo_reg;
    logic [CW-1:0]   count_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [XLEN-1:0] result_reg;

    logic            signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_q, special_r;
    logic [XLEN:0]   rem_shift, trial;
    logic [XLEN-1:0] fix_q, fix_r;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;

    // Operand conditioning and special-case detection work on the latched request.
    always_comb begin
        signed_op = ~op_reg[0];
        a_neg     = signed_op & dividend_reg[XLEN-1];
        b_neg     = signed_op & divisor_reg[XLEN-1];
        abs_a     = a_neg ? (~dividend_reg + 1'b1) : dividend_reg;
        abs_b     = b_neg ? (~divisor_reg + 1'b1) : divisor_reg;
        div_zero  = (divisor_reg == '0);
        overflow  = signed_op && (dividend_reg == MIN_INT) && (divisor_reg == ALL_ONES);
        special   = div_zero | overflow;
        special_q = div_zero ? ALL_ONES : MIN_INT;
        special_r = div_zero ? dividend_reg : '0;
    end

    // One restoring step: the trial subtract runs one bit wider so its MSB is the borrow.
    always_comb begin
        rem_shift = {rem_reg, quo_reg[XLEN-1]};
        trial     = rem_shift - {1'b0, dsr_reg};
        fix_q     = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
        fix_r     = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    end

`ifdef ALU_DIV_RESULT_CACHE_EN
    logic            cache_valid_reg;
    logic [XLEN-1:0] cache_a_reg;
    logic [XLEN-1:0] cache_b_reg;
    logic            cache_unsigned_reg;
    logic [XLEN-1:0] cache_q_reg;
    logic [XLEN-1:0] cache_r_reg;

    always_comb begin
        cache_hit    = cache_valid_reg
                       && (cache_a_reg == bus.rs1)
                       && (cache_b_reg == bus.rs2)
                       && (cache_unsigned_reg == bus.op[0]);
        cache_result = bus.op[1] ? cache_r_reg : cache_q_reg;
    end

    // The key is the raw request, so both the special and iterative paths record it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_reg    <= 1'b0;
            cache_a_reg        <= '0;
            cache_b_reg        <= '0;
            cache_unsigned_reg <= 1'b0;
            cache_q_reg        <= '0;
            cache_r_reg        <= '0;
        end else if (state_reg == S_PREP && special) begin
            cache_valid_reg    <= 1'b1;
            cache_a_reg        <= dividend_reg;
            cache_b_reg        <= divisor_reg;
            cache_unsigned_reg <= op_reg[0];
            cache_q_reg        <= special_q;
            cache_r_reg        <= special_r;
        end else if (state_reg == S_FIXUP) begin
            cache_valid_reg    <= 1'b1;
            cache_a_reg        <= dividend_reg;
            cache_b_reg        <= divisor_reg;
            cache_unsigned_reg <= op_reg[0];
            cache_q_reg        <= fix_q;
            cache_r_reg        <= fix_r;
        end
    end
`else
    always_comb begin
        cache_hit    = 1'b0;
        cache_result = '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = cache_hit ? S_DONE : S_PREP;
            S_PREP:  state_next = special ? S_DONE : S_ITER;
            S_ITER:  if (count_reg == '0) state_next = S_FIXUP;
            S_FIXUP: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_reg <= '0;
            divisor_reg  <= '0;
            op_reg       <= '0;
            dsr_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            count_reg    <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        dividend_reg <= bus.rs1;
                        divisor_reg  <= bus.rs2;
                        op_reg       <= bus.op;
                        if (cache_hit) begin
                            result_reg <= cache_result;
                        end
                    end
                end
                S_PREP: begin
                    if (special) begin
                        result_reg <= op_reg[1] ? special_r : special_q;
                    end else begin
                        quo_reg   <= abs_a;
                        dsr_reg   <= abs_b;
                        rem_reg   <= '0;
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        count_reg <= CW'(XLEN - 1);
                    end
                end
                S_ITER: begin
                    if (!trial[XLEN]) begin
                        rem_reg <= trial[XLEN-1:0];
                    end else begin
                        rem_reg <= rem_shift[XLEN-1:0];
                    end
                    quo_reg   <= {quo_reg[XLEN-2:0], ~trial[XLEN]};
                    count_reg <= count_reg - 1'b1;
                end
                S_FIXUP: begin
                    result_reg <= op_reg[1] ? fix_r : fix_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_reg != S_IDLE);
    assign bus.done   = (state_reg == S_DONE);
    assign bus.result = result_reg;
endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed bench for alu_div_sequencer: latency, results, special cases, start
// filtering, mid-operation reset and (when ALU_DIV_RESULT_CACHE_EN is defined) cache hits.
module tb_alu_div_sequencer;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
`ifdef ALU_DIV_RESULT_CACHE_EN
    localparam int LAT_REP35 = 1;
    localparam int LAT_REP2  = 1;
`else
    localparam int LAT_REP35 = 35;
    localparam int LAT_REP2  = 2;
`endif

    logic clk;
    logic rst;
    int   passed;
    int   total;

    alu_div_sequencer_if #(.XLEN(32)) bus ();

    alu_div_sequencer #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res, input string name);
        int n;
        bit busy_ok;
        kick(o, a, b);
        n = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        total++;
        if (n !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
        else passed++;
        total++;
        if (bus.result !== exp_res) $display("FAIL %s result: got %h expected %h", name, bus.result, exp_res);
        else passed++;
        total++;
        if (!busy_ok) $display("FAIL %s busy: got a low cycle expected busy=1 throughout", name);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, bus.done, bus.busy);
        else passed++;
        $display("txn %s op=%b rs1=%h rs2=%h latency=%0d result=%h", name, o, a, b, n, bus.result);
    endtask

    task automatic test_reset();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0)
            $display("FAIL reset_in: got busy=%b done=%b result=%h expected 0/0/0", bus.busy, bus.done, bus.result);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0)
            $display("FAIL reset_out: got busy=%b done=%b result=%h expected 0/0/0", bus.busy, bus.done, bus.result);
        else passed++;
        $display("txn reset busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    endtask

    task automatic test_basic();
        run_op(OP_DIV, 32'd100, 32'd7, 35, 32'd14, "div_100_7");
        run_op(OP_REM, 32'd100, 32'd7, LAT_REP35, 32'd2, "rem_100_7");
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.result !== 32'd2) $display("FAIL result_hold: got %h expected %h", bus.result, 32'd2);
        else passed++;
        $display("txn result_hold result=%h", bus.result);
    endtask

    task automatic test_signed();
        run_op(OP_REM,  32'hFFFFFFF9, 32'd2, 35,        32'hFFFFFFFF, "rem_m7_2");
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, LAT_REP35, 32'hFFFFFFFD, "div_m7_2");
        run_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, 35,        32'h7FFFFFFC, "divu_m7_2");
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 32'h80000000, 32'h0, 2, 32'hFFFFFFFF, "divu_by_0");
        run_op(OP_REMU, 32'h12345678, 32'h0, 2, 32'h12345678, "remu_by_0");
    endtask

    task automatic test_overflow();
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 2,        32'h80000000, "div_ovf");
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, LAT_REP2, 32'h0,        "rem_ovf");
    endtask

    task automatic test_busy_ignore();
        int n;
        bit stayed_idle;
        kick(OP_DIV, 32'd100, 32'd7);
        n = 1;
        while (bus.done !== 1'b1 && n < 100) begin
            if (n == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.rs1   = 32'd5;
                bus.rs2   = 32'd1;
            end
            if (n == 11) bus.start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 35) $display("FAIL busy_ignore latency: got %0d expected %0d", n, 35);
        else passed++;
        total++;
        if (bus.result !== 32'd14) $display("FAIL busy_ignore result: got %h expected %h", bus.result, 32'd14);
        else passed++;
        stayed_idle = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0) stayed_idle = 1'b0;
        end
        total++;
        if (!stayed_idle) $display("FAIL busy_ignore queued: got busy=1 after done expected idle");
        else passed++;
        $display("txn busy_ignore latency=%0d result=%h", n, bus.result);
    endtask

    task automatic test_reset_midop();
        int n;
        bit quiet;
        kick(OP_DIV, 32'd1000, 32'd3);
        n = 1;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL midrst busy: got %b expected 0", bus.busy);
        else passed++;
        total++;
        if (bus.done !== 1'b0) $display("FAIL midrst done: got %b expected 0", bus.done);
        else passed++;
        total++;
        if (bus.result !== 32'h0) $display("FAIL midrst result: got %h expected 0", bus.result);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) $display("FAIL midrst late_done: got activity after reset expected none");
        else passed++;
        $display("txn reset_midop busy=%b done=%b result=%h", bus.busy, bus.done, bus.result);
    endtask

    task automatic test_zero_dividend();
        run_op(OP_DIV, 32'd0, 32'd5, 35, 32'd0, "div_0_5");
    endtask

    task automatic test_start_on_done();
        int n;
        kick(OP_DIVU, 32'd200, 32'd7);
        n = 1;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (bus.result !== 32'd28) $display("FAIL sod first: got %h expected %h", bus.result, 32'd28);
        else passed++;
        bus.start = 1'b1;
        bus.op    = OP_REM;
        bus.rs1   = 32'd200;
        bus.rs2   = 32'd7;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0) $display("FAIL sod accepted_on_done: got busy=%b expected 0", bus.busy);
        else passed++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n !== 35) $display("FAIL sod latency: got %0d expected %0d", n, 35);
        else passed++;
        total++;
        if (bus.result !== 32'd4) $display("FAIL sod result: got %h expected %h", bus.result, 32'd4);
        else passed++;
        @(posedge clk);
        #1;
        $display("txn start_on_done latency=%0d result=%h", n, bus.result);
    endtask

`ifdef ALU_DIV_RESULT_CACHE_EN
    task automatic test_cache();
        run_op(OP_DIV,  32'd100, 32'd7, 35, 32'd14, "cache_fill");
        run_op(OP_REM,  32'd100, 32'd7, 1,  32'd2,  "cache_hit");
        run_op(OP_REMU, 32'd100, 32'd7, 35, 32'd2,  "cache_miss");
    endtask
`endif

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = 32'h0;
        bus.rs2   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_midop();
        test_zero_dividend();
        test_start_on_done();
`ifdef ALU_DIV_RESULT_CACHE_EN
        test_cache();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
